servo_pwm_capture: RTL and testbench

SERVO_PWM_CAPTURE -- requirements
Module: servo_pwm_capture

---
 rtl/servo_pkg.sv | 32 +++
 rtl/pwm_in_sync.sv | 66 ++++++
 rtl/servo_pwm_capture.sv | 199 +++++++++++++++++++
 tb/tb_servo_pwm_capture.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Purpose: shared types and constants for the servo PWM capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: capture FSM state type, angle limit, output widths, default tick
// counts and the front-end settle time (longer when SERVO_CAP_GLITCH_FILTER_EN
// is defined, because the filter adds four cycles before the level is trusted).
package servo_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } cap_state_t;

    localparam int MAX_ANGLE = 180;
    localparam int WIDTH_W   = 20;
    localparam int ANGLE_W   = 9;

    // Defaults assume a 100 MHz clk.
    localparam int DEF_MIN_TICKS     = 50000;
    localparam int DEF_MAX_TICKS     = 250000;
    localparam int DEF_TICKS_PER_DEG = 1111;
    localparam int DEF_TIMEOUT_TICKS = 2500000;

    // Cycles after reset before the synchronized level reflects pwm_in.
`ifdef SERVO_CAP_GLITCH_FILTER_EN
    localparam int SETTLE_CYCLES = 7;
`else
    localparam int SETTLE_CYCLES = 3;
`endif

endpackage

// File: rtl/pwm_in_sync.sv
// Purpose: brings pwm_in into the clk domain, optionally deglitches it, and detects edges.
// Latency: level valid 2 cycles after pwm_in (6 with SERVO_CAP_GLITCH_FILTER_EN); rise/fall combinational on level.
// Backpressure: none; free-running sampler.
// Ports: clk, rst_n (async active-low), pwm_in (asynchronous input);
//        level (synchronized/filtered input), rise/fall (one-cycle edge pulses).
// With SERVO_CAP_GLITCH_FILTER_EN the level only flips after 4 consecutive
// equal samples of the synchronized input, so pulses of 3 cycles or fewer vanish.
module pwm_in_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q;
    logic sync2_q;
    logic level_q;
    logic dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
        end
    end

`ifdef SERVO_CAP_GLITCH_FILTER_EN
    // run_q counts consecutive samples that disagree with the current level;
    // the fourth disagreeing sample commits the new level.
    logic [1:0] run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q   <= 2'd0;
            level_q <= 1'b0;
        end else if (sync2_q == level_q) begin
            run_q <= 2'd0;
        end else if (run_q == 2'd3) begin
            run_q   <= 2'd0;
            level_q <= sync2_q;
        end else begin
            run_q <= run_q + 2'd1;
        end
    end
`else
    assign level_q = sync2_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= level_q;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~dly_q;
    assign fall  = ~level_q & dly_q;

endmodule

// File: rtl/servo_pwm_capture.sv
// Purpose: measures servo PWM high time and decodes it to an angle with a counter-based (divider-free) scaler.
// Latency: valid 3 clk cycles after the pwm_in falling edge (7 with SERVO_CAP_GLITCH_FILTER_EN).
// Backpressure: none; valid is a one-cycle strobe and results hold until the next strobe.
// Ports: clk, rst_n (async active-low), pwm_in (asynchronous servo PWM);
//        pulse_width (high time in ticks), angle (0..180), valid (result strobe),
//        range_err (width outside [MIN_TICKS, MAX_TICKS]), timeout (no edge for TIMEOUT_TICKS).
// Optional macro: SERVO_CAP_GLITCH_FILTER_EN enables the input glitch filter.
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int MIN_TICKS     = DEF_MIN_TICKS,
    parameter int MAX_TICKS     = DEF_MAX_TICKS,
    parameter int TICKS_PER_DEG = DEF_TICKS_PER_DEG,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    output logic [WIDTH_W-1:0] pulse_width,
    output logic [ANGLE_W-1:0] angle,
    output logic               valid,
    output logic               range_err,
    output logic               timeout
);

    localparam logic [WIDTH_W-1:0] MIN_W     = WIDTH_W'(MIN_TICKS);
    localparam logic [WIDTH_W-1:0] MAX_W     = WIDTH_W'(MAX_TICKS);
    localparam logic [WIDTH_W-1:0] WIDTH_SAT = {WIDTH_W{1'b1}};
    localparam int                 PS_W      = (TICKS_PER_DEG > 1) ? $clog2(TICKS_PER_DEG) : 1;
    localparam logic [PS_W-1:0]    PS_LAST   = PS_W'(TICKS_PER_DEG - 1);
    localparam int                 TO_W      = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0]    TO_LIMIT  = TO_W'(TIMEOUT_TICKS);
    localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(MAX_ANGLE);
    localparam logic [2:0]         SETTLE_DONE = 3'(SETTLE_CYCLES);

    logic level;
    logic rise;
    logic fall;

    cap_state_t state_q;
    cap_state_t state_d;

    logic meas_start;
    logic meas_step;
    logic meas_done;

    logic [WIDTH_W-1:0] width_q;
    logic [PS_W-1:0]    ps_q;
    logic [ANGLE_W-1:0] deg_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [TO_W-1:0]    to_cnt_d;
    logic [2:0]         settle_q;
    logic               settled;
    logic               below;
    logic               above;

    pwm_in_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .level  (level),
        .rise   (rise),
        .fall   (fall)
    );

    // Synchronizer flops come out of reset at 0 regardless of pwm_in, so ARM
    // waits until they have sampled the real input; otherwise a pulse already
    // high at reset release would look like a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= 3'd0;
        end else if (!settled) begin
            settle_q <= settle_q + 3'd1;
        end
    end

    assign settled = (settle_q == SETTLE_DONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARM: begin
                if (settled && !level) state_d = ST_LOW;
            end
            ST_LOW: begin
                if (rise) state_d = ST_HIGH;
            end
            ST_HIGH: begin
                // A falling edge completes the pulse even if timeout rises together.
                if (fall)         state_d = ST_LOW;
                else if (timeout) state_d = ST_ARM;
            end
            default: state_d = ST_ARM;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        meas_start = 1'b0;
        meas_step  = 1'b0;
        meas_done  = 1'b0;
        case (state_q)
            ST_LOW: begin
                meas_start = rise;
            end
            ST_HIGH: begin
                meas_step = level;
                meas_done = fall;
            end
            default: ;
        endcase
    end

    // Width counter plus degree scaler. The prescaler only runs on cycles that
    // take the width beyond MIN_TICKS, so deg_q ends as
    // floor((width - MIN_TICKS) / TICKS_PER_DEG) without any divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q <= '0;
            ps_q    <= '0;
            deg_q   <= '0;
        end else if (meas_start) begin
            width_q <= WIDTH_W'(1);
            ps_q    <= '0;
            deg_q   <= '0;
        end else if (meas_step) begin
            if (width_q != WIDTH_SAT) begin
                width_q <= width_q + WIDTH_W'(1);
            end
            if (width_q >= MIN_W) begin
                if (ps_q == PS_LAST) begin
                    ps_q <= '0;
                    if (deg_q != ANGLE_MAX) begin
                        deg_q <= deg_q + ANGLE_W'(1);
                    end
                end else begin
                    ps_q <= ps_q + PS_W'(1);
                end
            end
        end
    end

    assign below = (width_q < MIN_W);
    assign above = (width_q > MAX_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid       <= 1'b0;
            pulse_width <= '0;
            angle       <= '0;
            range_err   <= 1'b0;
        end else begin
            valid <= meas_done;
            if (meas_done) begin
                pulse_width <= width_q;
                range_err   <= below | above;
                if (below) begin
                    angle <= '0;
                end else if (above) begin
                    angle <= ANGLE_MAX;
                end else begin
                    angle <= deg_q;
                end
            end
        end
    end

    // Edge-idle counter. timeout is registered from the next count so an edge
    // arriving in the cycle the limit would be reached keeps timeout low.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (rise || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LIMIT) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            timeout  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            timeout  <= (to_cnt_d == TO_LIMIT);
        end
    end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Purpose: directed self-checking bench for servo_pwm_capture with scaled-down tick parameters.
// Latency: expects valid 3 cycles after the falling edge (7 with SERVO_CAP_GLITCH_FILTER_EN).
// Backpressure: n/a; expected results are queued at stimulus time and popped on each valid.
// Scaling: MIN=200, MAX=1100, 5 ticks/deg, timeout 3000, period 2000, so a
// 650-tick pulse is 90 degrees, 200 is 0 and 1100 is 180.
module tb_servo_pwm_capture;

    localparam int MIN_T  = 200;
    localparam int MAX_T  = 1100;
    localparam int TPD    = 5;
    localparam int TO_T   = 3000;
    localparam int PERIOD = 2000;

`ifdef SERVO_CAP_GLITCH_FILTER_EN
    localparam int LAT  = 7;
    localparam bit FILT = 1'b1;
`else
    localparam int LAT  = 3;
    localparam bit FILT = 1'b0;
`endif

    typedef struct packed {
        logic [19:0] pw;
        logic [8:0]  ang;
        logic        err;
    } exp_t;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        pwm_in = 1'b0;
    logic [19:0] pulse_width;
    logic [8:0]  angle;
    logic        valid;
    logic        range_err;
    logic        timeout;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [19:0] last_pw  = '0;
    logic [8:0]  last_ang = '0;
    logic        last_err = 1'b0;

    always #5 clk = ~clk;

    servo_pwm_capture #(
        .MIN_TICKS     (MIN_T),
        .MAX_TICKS     (MAX_T),
        .TICKS_PER_DEG (TPD),
        .TIMEOUT_TICKS (TO_T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwm_in      (pwm_in),
        .pulse_width (pulse_width),
        .angle       (angle),
        .valid       (valid),
        .range_err   (range_err),
        .timeout     (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    // Scoreboard consumer: every valid strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_valid: got valid with pulse_width=%0d, want no valid", pulse_width);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("pulse_width", 32'(pulse_width), 32'(mon_e.pw));
                check("angle",       32'(angle),       32'(mon_e.ang));
                check("range_err",   32'(range_err),   32'(mon_e.err));
            end
        end
    end

    // One PWM period: high for 'high' cycles, then low for the rest.
    // Called and returns on a negedge.
    task automatic pulse(input int high, input int ang, input bit err, input bit want_valid);
        exp_t e;
        check("hold_pulse_width", 32'(pulse_width), 32'(last_pw));
        check("hold_angle",       32'(angle),       32'(last_ang));
        check("hold_range_err",   32'(range_err),   32'(last_err));
        e.pw  = 20'(high);
        e.ang = 9'(ang);
        e.err = err;
        if (want_valid) begin
            exp_q.push_back(e);
            last_pw  = e.pw;
            last_ang = e.ang;
            last_err = e.err;
        end
        pwm_in = 1'b1;
        repeat (high) @(negedge clk);
        pwm_in = 1'b0;
        repeat (LAT) @(negedge clk);
        check("valid_latency", 32'(valid), 32'(want_valid));
        check("timeout_after_pulse", 32'(timeout), 32'd0);
        repeat (PERIOD - high - LAT) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string phase);
        check({phase, "_valid"},       32'(valid),       32'd0);
        check({phase, "_pulse_width"}, 32'(pulse_width), 32'd0);
        check({phase, "_angle"},       32'(angle),       32'd0);
        check({phase, "_range_err"},   32'(range_err),   32'd0);
        check({phase, "_timeout"},     32'(timeout),     32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Nominal, periodic, and range boundaries.
        pulse(650,  90,  1'b0, 1'b1);
        pulse(650,  90,  1'b0, 1'b1);
        pulse(200,  0,   1'b0, 1'b1);
        pulse(1100, 180, 1'b0, 1'b1);
        pulse(207,  1,   1'b0, 1'b1);
        pulse(199,  0,   1'b1, 1'b1);
        pulse(120,  0,   1'b1, 1'b1);
        pulse(1101, 180, 1'b1, 1'b1);
        pulse(1300, 180, 1'b1, 1'b1);

        // Input held low past the timeout, then a normal pulse.
        check("timeout_before_idle", 32'(timeout), 32'd0);
        repeat (TO_T + 20) @(negedge clk);
        check("timeout_low", 32'(timeout), 32'd1);
        pulse(650, 90, 1'b0, 1'b1);

        // Input stuck high past the timeout: no result for that pulse.
        pwm_in = 1'b1;
        repeat (TO_T + 20) @(negedge clk);
        check("timeout_high", 32'(timeout), 32'd1);
        pwm_in = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("timeout_cleared_by_edge", 32'(timeout), 32'd0);
        repeat (200) @(negedge clk);
        pulse(650, 90, 1'b0, 1'b1);

        // Reset in the middle of a high phase.
        pwm_in = 1'b1;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("midreset");
        rst_n    = 1'b1;
        last_pw  = '0;
        last_ang = '0;
        last_err = 1'b0;
        repeat (400) @(negedge clk);
        pwm_in = 1'b0;
        repeat (PERIOD) @(negedge clk);
        pulse(650, 90, 1'b0, 1'b1);

        // Two-cycle glitch: measured without the filter, swallowed with it.
        pulse(2, 0, 1'b1, !FILT);
        pulse(650, 90, 1'b0, 1'b1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
